// File: rtl/cv32e40p_disc_window_ctrl.sv
// Discontinuity window controller.
// Watches the fetch stream between fetch and decode. Once enforcement is
// enabled, it counts non-zero straight-line instructions. When the stream
// runs W-1 instructions without a branch/jump, the next non-zero word is
// replaced by INJ_INSTR (jal x0,0). After that the controller parks in WAIT
// until resume_i. Handshake and data are pure pass-through (zero latency).
module cv32e40p_disc_window_ctrl #(
    parameter int unsigned MAX_WWDL  = 16,
    parameter logic [31:0] INJ_INSTR = 32'h0000006F,
    localparam int unsigned CW       = $clog2(MAX_WWDL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_en_i,
    input  logic          cfg_we_i,
    input  logic [CW-1:0] cfg_wwdl_i,
    input  logic          resume_i,
    input  logic          in_valid_i,
    input  logic [31:0]   in_rdata_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    output logic [31:0]   out_rdata_o,
    input  logic          out_ready_i,
    output logic [15:0]   inject_cnt_o,
    output logic [1:0]    state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_INJECT = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_wwdl;
    logic [15:0]   r_inj_cnt;

    logic          w_xfer;
    logic          w_nz;
    logic          w_disc;
    logic [CW-1:0] w_reload;
    logic [CW-1:0] w_cnt_dec;

    // Branch / jump decode for both 32-bit and compressed encodings.
    function automatic logic is_disc(input logic [31:0] w);
        logic r;
        r = 1'b0;
        if (w[1:0] == 2'b11) begin
            r = (w[6:2] == 5'b11000) || (w[6:2] == 5'b11011) ||
                ((w[6:2] == 5'b11001) && (w[14:12] == 3'b000));
        end else if (w[1:0] == 2'b01) begin
            // c.jal, c.j, c.beqz, c.bnez
            r = (w[15:13] == 3'b001) || (w[15:13] == 3'b101) ||
                (w[15:13] == 3'b110) || (w[15:13] == 3'b111);
        end else if (w[1:0] == 2'b10) begin
            // c.jr / c.jalr: rs2 field zero, rs1 non-zero
            r = (w[15:13] == 3'b100) && (w[6:2] == 5'd0) && (w[11:7] != 5'd0);
        end
        return r;
    endfunction

    // Window lengths below 2 would reload the counter to 0, so clamp.
    function automatic logic [CW-1:0] clamp_wwdl(input logic [CW-1:0] v);
        if (v < CW'(2))
            return CW'(2);
        else if (v > CW'(MAX_WWDL))
            return CW'(MAX_WWDL);
        else
            return v;
    endfunction

    assign w_xfer    = in_valid_i && out_ready_i;
    assign w_nz      = (in_rdata_i != 32'd0);
    assign w_disc    = is_disc(in_rdata_i);
    assign w_reload  = r_wwdl - CW'(1);
    assign w_cnt_dec = (r_cnt == '0) ? '0 : (r_cnt - CW'(1));

    assign out_valid_o  = in_valid_i;
    assign in_ready_o   = out_ready_i;
    // Keyed on the current state only, so the substitute holds steady while
    // backpressured and drops out as soon as reset forces IDLE.
    assign out_rdata_o  = ((r_state == S_INJECT) && w_nz) ? INJ_INSTR : in_rdata_i;
    assign inject_cnt_o = r_inj_cnt;
    assign state_o      = r_state;

    // Window length register; only read at reload time so a write never
    // disturbs a window already in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wwdl <= CW'(MAX_WWDL);
        end else if (cfg_we_i) begin
            r_wwdl <= clamp_wwdl(cfg_wwdl_i);
        end
    end

    // Window FSM with its countdown and the saturating injection counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= CW'(MAX_WWDL - 1);
            r_inj_cnt <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_en_i) begin
                        r_state <= S_COUNT;
                        r_cnt   <= w_reload;
                    end
                end
                S_COUNT: begin
                    if (!cfg_en_i) begin
                        r_state <= S_IDLE;
                    end else if (w_xfer && w_nz) begin
                        if (w_disc) begin
                            r_cnt <= w_reload;
                        end else begin
                            r_cnt <= w_cnt_dec;
                            if (w_cnt_dec == '0)
                                r_state <= S_INJECT;
                        end
                    end
                end
                S_INJECT: begin
                    if (w_xfer && w_nz) begin
                        if (r_inj_cnt != 16'hFFFF)
                            r_inj_cnt <= r_inj_cnt + 16'd1;
                        r_state <= cfg_en_i ? S_WAIT : S_IDLE;
                    end else if (!cfg_en_i && !(in_valid_i && w_nz)) begin
                        // Nothing half-delivered, so disabling can leave now.
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (!cfg_en_i) begin
                        r_state <= S_IDLE;
                    end else if (resume_i) begin
                        r_state <= S_COUNT;
                        r_cnt   <= w_reload;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40p_disc_window_ctrl.sv
// Directed bench for the discontinuity window controller.
module tb_cv32e40p_disc_window_ctrl;

    localparam int unsigned MAX_WWDL = 16;
    localparam int unsigned CW       = $clog2(MAX_WWDL + 1);
    localparam logic [31:0] NOP      = 32'h00000013;
    localparam logic [31:0] JINS     = 32'h0000006F;

    logic          clk;
    logic          rst;
    logic          cfg_en_i;
    logic          cfg_we_i;
    logic [CW-1:0] cfg_wwdl_i;
    logic          resume_i;
    logic          in_valid_i;
    logic [31:0]   in_rdata_i;
    logic          in_ready_o;
    logic          out_valid_o;
    logic [31:0]   out_rdata_o;
    logic          out_ready_i;
    logic [15:0]   inject_cnt_o;
    logic [1:0]    state_o;

    int n_total = 0;
    int n_bad   = 0;
    int exp_cnt = 0;

    cv32e40p_disc_window_ctrl #(
        .MAX_WWDL  (MAX_WWDL),
        .INJ_INSTR (JINS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_en_i     (cfg_en_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_wwdl_i   (cfg_wwdl_i),
        .resume_i     (resume_i),
        .in_valid_i   (in_valid_i),
        .in_rdata_i   (in_rdata_i),
        .in_ready_o   (in_ready_o),
        .out_valid_o  (out_valid_o),
        .out_rdata_o  (out_rdata_o),
        .out_ready_i  (out_ready_i),
        .inject_cnt_o (inject_cnt_o),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input int exp);
        chk(tag, {30'd0, state_o}, exp);
    endtask

    task automatic chk_cnt(input string tag);
        chk(tag, {16'd0, inject_cnt_o}, exp_cnt);
    endtask

    // One accepted word; checks the zero-latency output before the edge.
    task automatic send(input logic [31:0] w, input logic [31:0] exp, input string tag);
        in_valid_i  = 1'b1;
        in_rdata_i  = w;
        out_ready_i = 1'b1;
        #1;
        chk(tag, out_rdata_o, exp);
        tick();
        in_valid_i = 1'b0;
        in_rdata_i = 32'd0;
    endtask

    task automatic cfg_write(input logic [CW-1:0] v);
        cfg_wwdl_i = v;
        cfg_we_i   = 1'b1;
        tick();
        cfg_we_i   = 1'b0;
    endtask

    task automatic resume();
        resume_i = 1'b1;
        tick();
        resume_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_en_i = 1'b0; cfg_we_i = 1'b0; cfg_wwdl_i = '0;
        resume_i = 1'b0; in_valid_i = 1'b1; in_rdata_i = NOP; out_ready_i = 1'b0;
        tick();
        tick();
        // Reset state and pass-through
        chk_st("rst_state", 0);
        chk_cnt("rst_cnt");
        chk("rst_pass", out_rdata_o, NOP);
        chk("valid_pass", {31'd0, out_valid_o}, 1);
        chk("ready_pass0", {31'd0, in_ready_o}, 0);
        out_ready_i = 1'b1;
        #1;
        chk("ready_pass1", {31'd0, in_ready_o}, 1);
        in_valid_i = 1'b0; in_rdata_i = 32'd0; out_ready_i = 1'b0;
        rst = 1'b0;
        tick();

        // W=4, three straight-line words then injection
        cfg_write(CW'(4));
        cfg_en_i = 1'b1;
        tick();
        chk_st("en_count", 1);
        for (int i = 0; i < 3; i++) send(NOP, NOP, "w4_pass");
        chk_st("w4_inject", 2);
        send(NOP, JINS, "w4_repl");
        exp_cnt++;
        chk_st("w4_wait", 3);
        chk_cnt("w4_cnt");
        send(NOP, NOP, "wait_pass");
        chk_st("wait_stays", 3);

        // Branch mid-window reloads the counter
        resume();
        chk_st("resume_count", 1);
        send(NOP, NOP, "beq_p1");
        send(NOP, NOP, "beq_p2");
        send(32'h00000063, 32'h00000063, "beq_pass");
        send(NOP, NOP, "beq_p4");
        send(NOP, NOP, "beq_p5");
        chk_st("beq_still_count", 1);
        send(NOP, NOP, "beq_p6");
        chk_st("beq_inject", 2);
        send(NOP, JINS, "beq_repl7");
        exp_cnt++;
        chk_cnt("beq_cnt");

        // Zero words are transparent to the window
        resume();
        send(NOP, NOP, "z_p1");
        send(32'd0, 32'd0, "z_zero1");
        send(NOP, NOP, "z_p2");
        send(32'd0, 32'd0, "z_zero2");
        send(NOP, NOP, "z_p3");
        chk_st("z_inject", 2);
        send(32'd0, 32'd0, "z_zero_inj");
        chk_st("z_stay_inject", 2);
        chk_cnt("z_cnt_hold");
        send(NOP, JINS, "z_repl");
        exp_cnt++;
        chk_cnt("z_cnt");

        // jalr and compressed jump reload; compressed addi counts
        resume();
        send(NOP, NOP, "c_p1");
        send(32'h00008067, 32'h00008067, "c_jalr");
        send(32'h00000505, 32'h00000505, "c_addi");
        send(NOP, NOP, "c_p2");
        send(32'h0000A001, 32'h0000A001, "c_j");
        send(NOP, NOP, "c_p3");
        send(NOP, NOP, "c_p4");
        chk_st("c_count", 1);
        send(NOP, NOP, "c_p5");
        chk_st("c_inject", 2);

        // Backpressure during injection
        in_valid_i = 1'b1; in_rdata_i = NOP; out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold", out_rdata_o, JINS);
            tick();
            chk_cnt("bp_cnt_hold");
            chk_st("bp_state", 2);
        end
        send(NOP, JINS, "bp_accept");
        exp_cnt++;
        chk_cnt("bp_cnt");
        chk_st("bp_wait", 3);

        // Clamp low: W=2 injects after one word
        cfg_write(CW'(0));
        resume();
        send(NOP, NOP, "lo_p1");
        chk_st("lo_inject", 2);
        send(NOP, JINS, "lo_repl");
        exp_cnt++;

        // Clamp high: W=MAX injects after MAX-1 words
        cfg_write(CW'(MAX_WWDL + 5));
        resume();
        for (int i = 0; i < MAX_WWDL - 2; i++) send(NOP, NOP, "hi_pass");
        chk_st("hi_count", 1);
        send(NOP, NOP, "hi_last");
        chk_st("hi_inject", 2);
        send(NOP, JINS, "hi_repl");
        exp_cnt++;
        chk_cnt("hi_cnt");

        // Write coinciding with reload: reload uses old length 16
        cfg_wwdl_i = CW'(2); cfg_we_i = 1'b1; resume_i = 1'b1;
        tick();
        cfg_we_i = 1'b0; resume_i = 1'b0;
        send(NOP, NOP, "old_len");
        chk_st("old_len_count", 1);

        // Disable from COUNT; resume ignored while idle
        cfg_en_i = 1'b0;
        tick();
        chk_st("dis_count", 0);
        resume();
        chk_st("idle_resume", 0);
        send(NOP, NOP, "idle_pass");
        chk_st("idle_stay", 0);

        // Disable wins over resume in WAIT (length now 2)
        cfg_en_i = 1'b1;
        tick();
        send(NOP, NOP, "dw_p1");
        send(NOP, JINS, "dw_repl");
        exp_cnt++;
        chk_st("dw_wait", 3);
        cfg_en_i = 1'b0; resume_i = 1'b1;
        tick();
        resume_i = 1'b0;
        chk_st("dw_idle", 0);

        // Disable in INJECT with nothing presented
        cfg_en_i = 1'b1;
        tick();
        send(NOP, NOP, "di_p1");
        chk_st("di_inject", 2);
        cfg_en_i = 1'b0;
        tick();
        chk_st("di_idle", 0);

        // Disable in INJECT with a stalled word: finish it first
        cfg_en_i = 1'b1;
        tick();
        send(NOP, NOP, "dp_p1");
        cfg_en_i = 1'b0;
        in_valid_i = 1'b1; in_rdata_i = NOP; out_ready_i = 1'b0;
        tick();
        chk_st("dp_hold", 2);
        chk("dp_data", out_rdata_o, JINS);
        send(NOP, JINS, "dp_accept");
        exp_cnt++;
        chk_st("dp_idle", 0);
        chk_cnt("dp_cnt");

        // Reset mid-injection
        cfg_en_i = 1'b1;
        tick();
        send(NOP, NOP, "r_p1");
        in_valid_i = 1'b1; in_rdata_i = NOP; out_ready_i = 1'b0;
        #1;
        chk("r_inj_data", out_rdata_o, JINS);
        rst = 1'b1;
        #1;
        exp_cnt = 0;
        chk("r_data", out_rdata_o, NOP);
        chk_st("r_state", 0);
        chk_cnt("r_cnt");
        tick();
        rst = 1'b0;
        cfg_en_i = 1'b0;
        tick();
        send(NOP, NOP, "r_after");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
